// File: rtl/arbitro_nota_tono.sv
// Round-robin arbiter for the shared tone-generator note bus: grants one mode
// controller at a time, holds its latched note for a bounded time, then a silence gap.
module arbitro_nota_tono #(
    parameter int MIN_HOLD = 5_000_000,
    parameter int MAX_HOLD = 50_000_000,
    parameter int GAP      = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [8:0] notas_in,
    output logic [2:0] grant,
    output logic [2:0] notaSalida,
    output logic [2:0] nota_done,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [25:0] MIN_LAST = 26'(MIN_HOLD - 1);
    localparam logic [25:0] MAX_LAST = 26'(MAX_HOLD - 1);
    localparam logic [25:0] GAP_LAST = 26'(GAP - 1);

    state_t      state;
    logic [25:0] cnt;
    logic [1:0]  ptr;
    logic [1:0]  cur;

    logic [2:0]  nota_arr [3];
    logic [2:0]  elig;
    logic        pick_ok;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic        exit_play;

    // Index arithmetic modulo 3; both operands are always in 0..2.
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nota_arr[i] = notas_in[3*i +: 3];
            elig[i]     = req[i] && (nota_arr[i] >= 3'd1) && (nota_arr[i] <= 3'd4);
        end
    end

    // Search downwards so the candidate closest to ptr is the one that sticks.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 2'd0;
        cand     = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = wrap_add(ptr, 2'(k));
            if (elig[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign exit_play = ((cnt >= MIN_LAST) && !req[cur]) || (cnt == MAX_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 3'b000;
            notaSalida <= 3'd0;
            nota_done  <= 3'b000;
            busy       <= 1'b0;
            cnt        <= 26'd0;
            ptr        <= 2'd0;
            cur        <= 2'd0;
        end else begin
            nota_done <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (pick_ok) begin
                        state      <= ST_PLAY;
                        grant      <= 3'b001 << pick_idx;
                        notaSalida <= nota_arr[pick_idx];
                        cur        <= pick_idx;
                        cnt        <= 26'd0;
                        ptr        <= wrap_add(pick_idx, 2'd1);
                        busy       <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (exit_play) begin
                        state      <= ST_GAP;
                        nota_done  <= grant;
                        grant      <= 3'b000;
                        notaSalida <= 3'd0;
                        cnt        <= 26'd0;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 26'd0;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    grant      <= 3'b000;
                    notaSalida <= 3'd0;
                    busy       <= 1'b0;
                    cnt        <= 26'd0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_done_onehot  : assert property (@(posedge clk) disable iff (reset) $onehot0(nota_done));
    a_grant_play   : assert property (@(posedge clk) disable iff (reset)
                                      (grant != 3'b000) |-> (state == ST_PLAY));
`endif

endmodule

// File: tb/tb_arbitro_nota_tono.sv
// Bench for arbitro_nota_tono with MIN_HOLD=4, MAX_HOLD=10, GAP=2: cycle-by-cycle
// vector table through an expected-value queue, plus a hand sequence for reset mid-note.
module tb_arbitro_nota_tono;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [8:0] notas_in;
    logic [2:0] grant;
    logic [2:0] notaSalida;
    logic [2:0] nota_done;
    logic       busy;
    logic [1:0] state_dbg;

    int checks;
    int errors;

    // Expected word: {grant, notaSalida, nota_done, busy}
    logic [9:0] exp_q[$];

    typedef struct {
        logic [2:0] req;
        logic [8:0] notas;
        int         n;
        logic [2:0] grant;
        logic [2:0] nota;
        logic [2:0] done;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    arbitro_nota_tono #(
        .MIN_HOLD(4),
        .MAX_HOLD(10),
        .GAP(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .notas_in(notas_in),
        .grant(grant),
        .notaSalida(notaSalida),
        .nota_done(nota_done),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [2:0] r, input logic [8:0] n, input int cnt,
                                input logic [2:0] g, input logic [2:0] nt,
                                input logic [2:0] d, input logic b);
        vec_t v;
        v.req   = r;
        v.notas = n;
        v.n     = cnt;
        v.grant = g;
        v.nota  = nt;
        v.done  = d;
        v.busy  = b;
        tbl.push_back(v);
    endfunction

    task automatic check_out(input string name);
        logic [9:0] e;
        logic [9:0] act;
        e   = exp_q.pop_front();
        act = {grant, notaSalida, nota_done, busy};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got grant=%b nota=%0d done=%b busy=%b, want grant=%b nota=%0d done=%b busy=%b",
                     name, act[9:7], act[6:4], act[3:1], act[0], e[9:7], e[6:4], e[3:1], e[0]);
        end
    endtask

    task automatic drive_cycle(input logic [2:0] r, input logic [8:0] n,
                               input logic [9:0] e, input string name);
        @(negedge clk);
        req      = r;
        notas_in = n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    localparam logic [8:0] RR = 9'b100_010_001;  // notes 1/2/4
    localparam logic [8:0] S1 = 9'b000_000_011;
    localparam logic [8:0] IV = 9'b000_110_000;  // note0=0, note1=6
    localparam logic [8:0] V4 = 9'b000_100_000;
    localparam logic [8:0] ST = 9'b000_010_000;
    localparam logic [8:0] L1 = 9'b000_000_001;
    localparam logic [8:0] L4 = 9'b000_000_100;
    localparam logic [8:0] R3 = 9'b000_011_000;
    localparam logic [8:0] RB = 9'b100_011_000;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        req      = 3'b000;
        notas_in = 9'd0;

        // Round robin from ptr=0, each req dropped after its grant
        add(3'b111, RR, 1, 3'b001, 3'd1, 3'b000, 1'b1);
        add(3'b110, RR, 3, 3'b001, 3'd1, 3'b000, 1'b1);
        add(3'b110, RR, 1, 3'b000, 3'd0, 3'b001, 1'b1);
        add(3'b110, RR, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b110, RR, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        add(3'b110, RR, 1, 3'b010, 3'd2, 3'b000, 1'b1);
        add(3'b100, RR, 3, 3'b010, 3'd2, 3'b000, 1'b1);
        add(3'b100, RR, 1, 3'b000, 3'd0, 3'b010, 1'b1);
        add(3'b100, RR, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b100, RR, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        add(3'b100, RR, 1, 3'b100, 3'd4, 3'b000, 1'b1);
        add(3'b000, RR, 3, 3'b100, 3'd4, 3'b000, 1'b1);
        add(3'b000, RR, 1, 3'b000, 3'd0, 3'b100, 1'b1);
        add(3'b000, RR, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b000, RR, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        // ptr back at 0: with 0 and 1 both eligible, 0 wins
        add(3'b011, RR, 1, 3'b001, 3'd1, 3'b000, 1'b1);
        add(3'b000, RR, 3, 3'b001, 3'd1, 3'b000, 1'b1);
        add(3'b000, RR, 1, 3'b000, 3'd0, 3'b001, 1'b1);
        add(3'b000, RR, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b000, RR, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        // Single short request: held one cycle, still plays MIN_HOLD
        add(3'b001, S1, 1, 3'b001, 3'd3, 3'b000, 1'b1);
        add(3'b000, S1, 3, 3'b001, 3'd3, 3'b000, 1'b1);
        add(3'b000, S1, 1, 3'b000, 3'd0, 3'b001, 1'b1);
        add(3'b000, S1, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b000, S1, 2, 3'b000, 3'd0, 3'b000, 1'b0);
        // Invalid codes ignored, then a valid code is granted next edge
        add(3'b011, IV, 3, 3'b000, 3'd0, 3'b000, 1'b0);
        add(3'b011, V4, 1, 3'b010, 3'd4, 3'b000, 1'b1);
        add(3'b000, V4, 3, 3'b010, 3'd4, 3'b000, 1'b1);
        add(3'b000, V4, 1, 3'b000, 3'd0, 3'b010, 1'b1);
        add(3'b000, V4, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b000, V4, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        // Stuck request: capped at MAX_HOLD, gap, one IDLE cycle, re-grant
        add(3'b010, ST, 10, 3'b010, 3'd2, 3'b000, 1'b1);
        add(3'b010, ST, 1, 3'b000, 3'd0, 3'b010, 1'b1);
        add(3'b010, ST, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b010, ST, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        add(3'b010, ST, 1, 3'b010, 3'd2, 3'b000, 1'b1);
        add(3'b000, ST, 3, 3'b010, 3'd2, 3'b000, 1'b1);
        add(3'b000, ST, 1, 3'b000, 3'd0, 3'b010, 1'b1);
        add(3'b000, ST, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b000, ST, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        // Note changes 1->4 during PLAY: latched 1 stays
        add(3'b001, L1, 1, 3'b001, 3'd1, 3'b000, 1'b1);
        add(3'b001, L4, 3, 3'b001, 3'd1, 3'b000, 1'b1);
        add(3'b000, L4, 1, 3'b000, 3'd0, 3'b001, 1'b1);
        add(3'b000, L4, 1, 3'b000, 3'd0, 3'b000, 1'b1);
        add(3'b000, L4, 1, 3'b000, 3'd0, 3'b000, 1'b0);
        // Grant requester 1 (ptr moves to 2), two PLAY cycles before reset
        add(3'b010, R3, 2, 3'b010, 3'd3, 3'b000, 1'b1);

        // Reset state
        #12;
        exp_q.push_back(10'd0);
        check_out("reset_state");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                drive_cycle(tbl[i].req, tbl[i].notas,
                            {tbl[i].grant, tbl[i].nota, tbl[i].done, tbl[i].busy},
                            $sformatf("vec%0d_cyc%0d", i, k));
            end
        end

        // Reset mid-PLAY: outputs clear at once, no done pulse, ptr back to 0
        @(negedge clk);
        reset    = 1'b1;
        req      = 3'b110;
        notas_in = RB;
        #1;
        exp_q.push_back(10'd0);
        check_out("reset_mid_play");
        @(posedge clk);
        #1;
        exp_q.push_back(10'd0);
        check_out("reset_held_edge");
        reset = 1'b0;
        drive_cycle(3'b110, RB, {3'b010, 3'd3, 3'b000, 1'b1}, "post_reset_grant");
        for (int k = 0; k < 3; k++) begin
            drive_cycle(3'b000, RB, {3'b010, 3'd3, 3'b000, 1'b1}, $sformatf("post_reset_play%0d", k));
        end
        drive_cycle(3'b000, RB, {3'b000, 3'd0, 3'b010, 1'b1}, "post_reset_done");
        drive_cycle(3'b000, RB, {3'b000, 3'd0, 3'b000, 1'b1}, "post_reset_gap");
        drive_cycle(3'b000, RB, {3'b000, 3'd0, 3'b000, 1'b0}, "post_reset_idle");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
